// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver
// Time-multiplexes a captured pair of hex digits onto one shared active-low
// 7-segment bus with two active-low anode selects. A one-hot refresh FSM
// alternates right/left phases with a blanking gap at every switch, and the
// digit pair is latched once per frame so a display never shows a torn pair.
module seven_seg_mux_driver #(
  parameter logic [23:0] REFRESH_COUNT = 24'd100000,
  parameter logic [7:0]  BLANK_CYCLES  = 8'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] left,
  input  logic [3:0] right,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic       an_left,
  output logic       an_right
);

  typedef enum logic [3:0] {
    BLANK_L2R = 4'b0001,
    SHOW_R    = 4'b0010,
    BLANK_R2L = 4'b0100,
    SHOW_L    = 4'b1000
  } state_t;

  // Terminal counts for the two kinds of phase.
  localparam logic [23:0] SHOW_LAST  = REFRESH_COUNT - 24'd1;
  localparam logic [23:0] BLANK_LAST = {16'd0, BLANK_CYCLES} - 24'd1;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  state_t      state_r;
  logic [23:0] cnt_r;
  logic [3:0]  l_sh_r;
  logic [3:0]  r_sh_r;

  // Hex digit to active-low {g,f,e,d,c,b,a} cathode pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      4'hF:    pattern = 7'b0001110;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

  // Refresh FSM: phase counter, state sequencing and once-per-frame digit capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BLANK_L2R;
      cnt_r   <= 24'd0;
      l_sh_r  <= 4'd0;
      r_sh_r  <= 4'd0;
    end else begin
      case (state_r)
        BLANK_L2R: begin
          if (cnt_r == BLANK_LAST) begin
            state_r <= SHOW_R;
            cnt_r   <= 24'd0;
            // Frame boundary: both digits are taken from the same edge.
            l_sh_r  <= left;
            r_sh_r  <= right;
          end else begin
            cnt_r <= cnt_r + 24'd1;
          end
        end
        SHOW_R: begin
          if (cnt_r == SHOW_LAST) begin
            state_r <= BLANK_R2L;
            cnt_r   <= 24'd0;
          end else begin
            cnt_r <= cnt_r + 24'd1;
          end
        end
        BLANK_R2L: begin
          if (cnt_r == BLANK_LAST) begin
            state_r <= SHOW_L;
            cnt_r   <= 24'd0;
          end else begin
            cnt_r <= cnt_r + 24'd1;
          end
        end
        SHOW_L: begin
          if (cnt_r == SHOW_LAST) begin
            state_r <= BLANK_L2R;
            cnt_r   <= 24'd0;
          end else begin
            cnt_r <= cnt_r + 24'd1;
          end
        end
        default: begin
          // Corrupted one-hot code: restart the frame from the blank gap.
          state_r <= BLANK_L2R;
          cnt_r   <= 24'd0;
        end
      endcase
    end
  end

  // Output decode: only a show phase with the display enabled lights one anode.
  always_comb begin
    seg      = SEG_OFF;
    an_left  = 1'b1;
    an_right = 1'b1;
    if (disp_en) begin
      case (state_r)
        SHOW_R: begin
          seg      = hex_to_seg(r_sh_r);
          an_right = 1'b0;
          an_left  = 1'b1;
        end
        SHOW_L: begin
          seg      = hex_to_seg(l_sh_r);
          an_left  = 1'b0;
          an_right = 1'b1;
        end
        default: begin
          seg      = SEG_OFF;
          an_left  = 1'b1;
          an_right = 1'b1;
        end
      endcase
    end else begin
      seg      = SEG_OFF;
      an_left  = 1'b1;
      an_right = 1'b1;
    end
  end

endmodule
